// File: rtl/ldpc_enc_pkg.sv
// ----------------------------------------------------------------------------
// ldpc_enc_pkg
// Shared definitions for the LDPC encoder controller slice.
//   - one-hot FSM state encoding (also driven out on fsm_state)
//   - info-byte counts for the two code rates and the default frame length
//   - counter width used by every byte/cycle counter in the controller
//   - info_bytes(): maps the latched rate bit to the info-byte count K
// No ports (package).
// ----------------------------------------------------------------------------
package ldpc_enc_pkg;

    localparam int CNT_W           = 11;
    localparam int FRAME_BYTES_DEF = 1152;
    localparam int K_R12           = 576;
    localparam int K_R34           = 864;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0001,
        ST_DATA_IN  = 4'b0010,
        ST_PARITY   = 4'b0100,
        ST_DATA_OUT = 4'b1000
    } state_t;

    // Rate 0 is the 1/2 code, rate 1 the 3/4 code.
    function automatic logic [CNT_W-1:0] info_bytes(input logic rate);
        return rate ? CNT_W'(K_R34) : CNT_W'(K_R12);
    endfunction

endpackage

// File: rtl/ldpc_enc_out_stage.sv
// ----------------------------------------------------------------------------
// ldpc_enc_out_stage
// Codeword read-out stage with a 1-deep prefetch. A memory read is issued
// whenever the single output register is empty or being drained, so a byte
// is presented every cycle while out_ready stays high, and the presented
// byte (and the memory output behind it) is frozen while out_ready is low.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear        : frame start, clears the read counter and output register
//   active       : high while the controller is in DATA_OUT
//   k_val        : info-byte count of the current frame
//   out_ready    : downstream accepts the presented byte
//   rd_en        : memory read strobe (address is rd_cnt)
//   rd_cnt       : index of the next byte to read
//   out_valid    : a codeword byte is presented
//   out_sel      : presented byte is parity (index >= k_val)
//   sop, eop     : presented byte is the first / last of the codeword
// ----------------------------------------------------------------------------
module ldpc_enc_out_stage
    import ldpc_enc_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             active,
    input  logic [CNT_W-1:0] k_val,
    input  logic             out_ready,
    output logic             rd_en,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             out_valid,
    output logic             out_sel,
    output logic             sop,
    output logic             eop
);

    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_BYTES - 1);

    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sel_q, out_sel_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;

    // Read whenever the output register will be free at the next edge;
    // the counter stops at the frame length so it never wraps.
    assign rd_en = active && (rd_cnt_q < FRAME_LEN) && (!out_valid_q || out_ready);

    // The tag bits are captured together with the read so they always
    // describe the byte currently sitting in the memory output register.
    always_comb begin
        rd_cnt_d    = rd_cnt_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        if (clear) begin
            rd_cnt_d    = '0;
            out_valid_d = 1'b0;
            out_sel_d   = 1'b0;
            sop_d       = 1'b0;
            eop_d       = 1'b0;
        end else if (rd_en) begin
            rd_cnt_d    = rd_cnt_q + CNT_W'(1);
            out_valid_d = 1'b1;
            out_sel_d   = (rd_cnt_q >= k_val);
            sop_d       = (rd_cnt_q == '0);
            eop_d       = (rd_cnt_q == LAST_IDX);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_sel_d   = 1'b0;
            sop_d       = 1'b0;
            eop_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
        end else begin
            rd_cnt_q    <= rd_cnt_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
        end
    end

    assign rd_cnt    = rd_cnt_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
    assign sop       = sop_q;
    assign eop       = eop_q;

endmodule

// File: rtl/ldpc_enc_ctrl.sv
// ----------------------------------------------------------------------------
// ldpc_enc_ctrl
// Frame controller for an LDPC encoder. A frame runs through four phases:
// collect K info bytes into memory, step the parity recursion P times,
// drain the datapath pipeline for DLY_PAR cycles, then read the whole
// FRAME_BYTES codeword back out through the prefetch output stage.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   sync_in, rate       : frame start pulse and code rate (used only in IDLE)
//   in_valid, in_ready  : info-byte handshake
//   wr_info, par_acc    : info write strobe / parity accumulate enable
//   par_step            : parity recursion step enable
//   mem_addr            : address for the active write, step or read
//   rd_en               : memory read strobe
//   out_valid,out_ready : codeword-byte handshake
//   out_sel, sop, eop   : parity flag, first and last byte flags
//   busy                : frame in progress
//   fsm_state           : one-hot state
//   err_sync            : sync_in seen outside IDLE (one-cycle pulse)
// ----------------------------------------------------------------------------
module ldpc_enc_ctrl
    import ldpc_enc_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int DLY_PAR     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync_in,
    input  logic             rate,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_info,
    output logic             par_acc,
    output logic             par_step,
    output logic [CNT_W-1:0] mem_addr,
    output logic             rd_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sel,
    output logic             sop,
    output logic             eop,
    output logic             busy,
    output logic [3:0]       fsm_state,
    output logic             err_sync
);

    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_BYTES);
    localparam logic [CNT_W-1:0] DLY_LAST  = (DLY_PAR > 0) ? CNT_W'(DLY_PAR - 1) : '0;

    state_t           state_q, state_d;
    logic             rate_q, rate_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] par_cnt_q, par_cnt_d;
    logic [CNT_W-1:0] dly_cnt_q, dly_cnt_d;
    logic             busy_q, busy_d;
    logic             err_sync_q, err_sync_d;

    logic [CNT_W-1:0] k_val;
    logic [CNT_W-1:0] p_val;
    logic             start;
    logic             eop_xfer;
    logic [CNT_W-1:0] rd_cnt;

    // K/P follow the latched rate, which only changes on an honoured start.
    assign k_val = info_bytes(rate_q);
    assign p_val = FRAME_LEN - k_val;

    // in_ready is low in IDLE, so a stale in_valid beside sync_in is ignored.
    assign in_ready = (state_q == ST_DATA_IN) && (in_cnt_q < k_val);
    assign wr_info  = in_valid && in_ready;
    assign par_acc  = wr_info;
    assign par_step = (state_q == ST_PARITY) && (par_cnt_q < p_val);
    assign eop_xfer = out_valid && out_ready && eop;

    // Next-state and counter logic. Counters only move while their phase is
    // active and below the terminal count, so none of them can wrap.
    always_comb begin
        state_d    = state_q;
        rate_d     = rate_q;
        in_cnt_d   = in_cnt_q;
        par_cnt_d  = par_cnt_q;
        dly_cnt_d  = dly_cnt_q;
        busy_d     = busy_q;
        err_sync_d = sync_in && (state_q != ST_IDLE);
        start      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync_in) begin
                    start     = 1'b1;
                    state_d   = ST_DATA_IN;
                    rate_d    = rate;
                    in_cnt_d  = '0;
                    par_cnt_d = '0;
                    dly_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
            ST_DATA_IN: begin
                if (wr_info) begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if (in_cnt_q == k_val - CNT_W'(1)) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                // Step phase first; once all P steps are issued the
                // remaining cycles count out the pipeline drain.
                if (par_step) begin
                    par_cnt_d = par_cnt_q + CNT_W'(1);
                    if ((DLY_PAR == 0) && (par_cnt_q == p_val - CNT_W'(1))) begin
                        state_d = ST_DATA_OUT;
                    end
                end else begin
                    dly_cnt_d = dly_cnt_q + CNT_W'(1);
                    if (dly_cnt_q == DLY_LAST) begin
                        state_d = ST_DATA_OUT;
                    end
                end
            end
            ST_DATA_OUT: begin
                if (eop_xfer) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rate_q     <= 1'b0;
            in_cnt_q   <= '0;
            par_cnt_q  <= '0;
            dly_cnt_q  <= '0;
            busy_q     <= 1'b0;
            err_sync_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rate_q     <= rate_d;
            in_cnt_q   <= in_cnt_d;
            par_cnt_q  <= par_cnt_d;
            dly_cnt_q  <= dly_cnt_d;
            busy_q     <= busy_d;
            err_sync_q <= err_sync_d;
        end
    end

    // Parity storage sits directly above the info bytes in the shared memory.
    // The address is parked at zero whenever no strobe is active.
    always_comb begin
        mem_addr = '0;
        if (wr_info) begin
            mem_addr = in_cnt_q;
        end else if (par_step) begin
            mem_addr = k_val + par_cnt_q;
        end else if (rd_en) begin
            mem_addr = rd_cnt;
        end
    end

    ldpc_enc_out_stage #(
        .FRAME_BYTES (FRAME_BYTES)
    ) u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .clear     (start),
        .active    (state_q == ST_DATA_OUT),
        .k_val     (k_val),
        .out_ready (out_ready),
        .rd_en     (rd_en),
        .rd_cnt    (rd_cnt),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .sop       (sop),
        .eop       (eop)
    );

    assign busy      = busy_q;
    assign err_sync  = err_sync_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_ldpc_enc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ldpc_enc_ctrl
// Directed frame-level bench for ldpc_enc_ctrl. Each frame pushes its
// expected codeword byte records into a scoreboard queue when sync_in is
// driven; a small memory model captures mem_addr on every rd_en and the
// value it holds is popped against the queue on every output transfer.
// ----------------------------------------------------------------------------
module tb_ldpc_enc_ctrl;

    localparam int FRAME   = 1152;
    localparam int DLY_PAR = 4;

    typedef struct packed {
        logic [10:0] idx;
        logic        sel;
        logic        sop;
        logic        eop;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sync_in;
    logic        rate;
    logic        in_valid;
    logic        in_ready;
    logic        wr_info;
    logic        par_acc;
    logic        par_step;
    logic [10:0] mem_addr;
    logic        rd_en;
    logic        out_valid;
    logic        out_ready;
    logic        out_sel;
    logic        sop;
    logic        eop;
    logic        busy;
    logic [3:0]  fsm_state;
    logic        err_sync;

    int          checks   = 0;
    int          failures = 0;

    exp_t        exp_q[$];
    int          wr_seen, par_seen, rd_seen;
    int          exp_k, exp_p;
    logic [10:0] mem_q = '0;
    logic        rd_en_s;
    logic [10:0] addr_s;
    logic        err_pending = 1'b0;
    logic        err_due     = 1'b0;
    logic        sb_done;
    bit          ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    ldpc_enc_ctrl #(
        .FRAME_BYTES (FRAME),
        .DLY_PAR     (DLY_PAR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sync_in   (sync_in),
        .rate      (rate),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_info   (wr_info),
        .par_acc   (par_acc),
        .par_step  (par_step),
        .mem_addr  (mem_addr),
        .rd_en     (rd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .sop       (sop),
        .eop       (eop),
        .busy      (busy),
        .fsm_state (fsm_state),
        .err_sync  (err_sync)
    );

    always #5 clk = ~clk;

    // Hard stop in case a phase loop is ever miscounted.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic iv,
                                 input logic ordy);
        sync_in   = s;
        rate      = r;
        in_valid  = iv;
        out_ready = ordy;
    endtask

    // Samples at the falling edge: address traces, err_sync, and scoreboard
    // pops for every output transfer.
    task automatic observeCycle();
        exp_t rec;
        @(negedge clk);
        rd_en_s = rd_en;
        addr_s  = mem_addr;
        checkOutput("err_sync", err_sync, err_due);
        if (wr_info) begin
            checkOutput("wr_addr", mem_addr, wr_seen);
            wr_seen++;
        end
        if (par_step) begin
            checkOutput("par_addr", mem_addr, exp_k + par_seen);
            par_seen++;
        end
        if (rd_en) begin
            checkOutput("rd_addr", mem_addr, rd_seen);
            rd_seen++;
        end
        if (out_valid && out_ready) begin
            checkOutput("sb_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                rec = exp_q.pop_front();
                checkOutput("out_byte", mem_q, rec.idx);
                checkOutput("out_sel", out_sel, rec.sel);
                checkOutput("sop", sop, rec.sop);
                checkOutput("eop", eop, rec.eop);
                if (rec.eop) sb_done = 1'b1;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rd_en_s) mem_q = addr_s;
        err_due     = err_pending;
        err_pending = 1'b0;
        #1;
    endtask

    task automatic checkResetState();
        checkOutput("rst_state", fsm_state, 4'b0001);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_wr_info", wr_info, 0);
        checkOutput("rst_par_acc", par_acc, 0);
        checkOutput("rst_par_step", par_step, 0);
        checkOutput("rst_rd_en", rd_en, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_sel", out_sel, 0);
        checkOutput("rst_sop", sop, 0);
        checkOutput("rst_eop", eop, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err_sync", err_sync, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
    endtask

    // One frame: stall adds in_valid gaps and the 1,0,0,1 out_ready pattern,
    // err_at pulses sync_in (with the opposite rate) at that input count,
    // abort_par asserts reset at that parity step and ends the frame.
    task automatic runFrame(input logic r, input bit stall, input int err_at,
                            input int abort_par);
        int   cyc;
        int   rd_before;
        logic iv, ordy, s, rr;
        logic exp_ov, exp_rd, prev_rd, prev_ov, prev_ordy;
        bit   err_sent;
        exp_k    = r ? 864 : 576;
        exp_p    = FRAME - exp_k;
        wr_seen  = 0;
        par_seen = 0;
        rd_seen  = 0;
        sb_done  = 1'b0;
        err_sent = 1'b0;
        exp_q.delete();
        for (int i = 0; i < FRAME; i++) begin
            exp_q.push_back('{idx: 11'(i), sel: (i >= exp_k), sop: (i == 0),
                              eop: (i == FRAME - 1)});
        end

        applyStimulus(1'b1, r, 1'b1, 1'b1);
        observeCycle();
        checkOutput("idle_state", fsm_state, 4'b0001);
        checkOutput("idle_in_ready", in_ready, 0);
        checkOutput("idle_wr_info", wr_info, 0);
        checkOutput("idle_busy", busy, 0);
        advance();

        cyc = 0;
        while (wr_seen < exp_k && cyc < 2 * exp_k + 16) begin
            iv = stall ? ((cyc % 7) != 3) : 1'b1;
            s  = 1'b0;
            rr = r;
            if (err_at >= 0 && wr_seen == err_at && !err_sent) begin
                s           = 1'b1;
                rr          = ~r;
                err_pending = 1'b1;
                err_sent    = 1'b1;
            end
            applyStimulus(s, rr, iv, 1'b1);
            observeCycle();
            checkOutput("din_state", fsm_state, 4'b0010);
            checkOutput("din_in_ready", in_ready, 1);
            checkOutput("din_wr_info", wr_info, iv);
            checkOutput("din_par_acc", par_acc, iv);
            checkOutput("din_busy", busy, 1);
            advance();
            cyc++;
        end
        checkOutput("in_count", wr_seen, exp_k);

        for (int i = 0; i < exp_p; i++) begin
            if (i == abort_par) reset = 1'b1;
            applyStimulus(1'b0, r, 1'b1, 1'b1);
            observeCycle();
            checkOutput("par_state", fsm_state, 4'b0100);
            checkOutput("par_step", par_step, 1);
            checkOutput("par_in_ready", in_ready, 0);
            checkOutput("par_wr_info", wr_info, 0);
            advance();
            if (i == abort_par) begin
                reset = 1'b0;
                applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
                observeCycle();
                checkResetState();
                advance();
                return;
            end
        end
        checkOutput("par_count", par_seen, exp_p);

        for (int i = 0; i < DLY_PAR; i++) begin
            applyStimulus(1'b0, r, 1'b0, 1'b1);
            observeCycle();
            checkOutput("dly_state", fsm_state, 4'b0100);
            checkOutput("dly_par_step", par_step, 0);
            checkOutput("dly_rd_en", rd_en, 0);
            advance();
        end

        prev_rd   = 1'b0;
        prev_ov   = 1'b0;
        prev_ordy = 1'b1;
        cyc       = 0;
        while (!sb_done && cyc < 4 * FRAME) begin
            ordy = stall ? ready_pat[cyc % 4] : 1'b1;
            applyStimulus(1'b0, r, 1'b0, ordy);
            rd_before = rd_seen;
            observeCycle();
            exp_ov = prev_rd || (prev_ov && !prev_ordy);
            exp_rd = (rd_before < FRAME) && (!exp_ov || ordy);
            checkOutput("dout_state", fsm_state, 4'b1000);
            checkOutput("dout_busy", busy, 1);
            checkOutput("dout_out_valid", out_valid, exp_ov);
            checkOutput("dout_rd_en", rd_en, exp_rd);
            prev_rd   = exp_rd;
            prev_ov   = exp_ov;
            prev_ordy = ordy;
            advance();
            cyc++;
        end
        checkOutput("eop_seen", sb_done, 1);

        applyStimulus(1'b0, r, 1'b0, 1'b1);
        observeCycle();
        checkOutput("end_state", fsm_state, 4'b0001);
        checkOutput("end_busy", busy, 0);
        checkOutput("end_out_valid", out_valid, 0);
        checkOutput("rd_count", rd_seen, FRAME);
        checkOutput("sb_empty", exp_q.size(), 0);
        advance();
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        advance();
        advance();
        observeCycle();
        checkResetState();
        advance();
        reset = 1'b0;

        $display("[TB] rate 1/2 frame");
        runFrame(1'b0, 1'b0, -1, -1);
        $display("[TB] rate 3/4 frame");
        runFrame(1'b1, 1'b0, -1, -1);
        $display("[TB] stalled frame");
        runFrame(1'b0, 1'b1, -1, -1);
        $display("[TB] sync_in mid-frame");
        runFrame(1'b0, 1'b0, 100, -1);
        $display("[TB] reset in parity");
        runFrame(1'b0, 1'b0, -1, 200);
        $display("[TB] frame after reset");
        runFrame(1'b0, 1'b0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
